// File: rtl/intc_mmio_pkg.sv
// Shared types and constants for the memory-mapped interrupt controller.
//   intc_reg_e : register offsets within the 8-word window
//   cause_t    : layout of the CAUSE register
//   MODE_EDGE / MODE_LEVEL : per-bit MODE register encodings
package intc_pkg;

  typedef enum logic [2:0] {
    INTC_PENDING = 3'd0,
    INTC_ENABLE  = 3'd1,
    INTC_MODE    = 3'd2,
    INTC_CAUSE   = 3'd3,
    INTC_ACK     = 3'd4
  } intc_reg_e;

  typedef struct packed {
    logic        valid;
    logic [25:0] reserved;
    logic [4:0]  index;
  } cause_t;

  localparam logic MODE_EDGE  = 1'b1;
  localparam logic MODE_LEVEL = 1'b0;

endpackage

// File: rtl/intc_mmio_if.sv
// CU-side memory bus as seen by the interrupt controller.
//   addr/wdata/mem_rd/mem_wr : driven by the CU (master)
//   rdata/oe_rdata           : driven by the responder (slave); rdata is 0 when not driving
interface intc_mmio_if;

  logic [15:0] addr;
  logic [31:0] wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] rdata;
  logic        oe_rdata;

  modport master (
    output addr, wdata, mem_rd, mem_wr,
    input  rdata, oe_rdata
  );

  modport slave (
    input  addr, wdata, mem_rd, mem_wr,
    output rdata, oe_rdata
  );

endinterface

// File: rtl/intc_mmio_sync_bits.sv
// Multi-bit flop-chain synchronizer for independent asynchronous request lines.
//   clk : destination clock
//   rst : asynchronous active-low clear of every stage
//   d   : asynchronous inputs
//   q   : inputs after STAGES flops
module sync_bits #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/intc_mmio.sv
// Memory-mapped interrupt controller sitting beside main memory on the CU bus.
// Latches peripheral requests (edge or level per bit), masks them with ENABLE and raises
// a registered hwint to the CU. Software inspects CAUSE and clears via W1C or ACK.
//   clk   : single clock
//   rst   : asynchronous active-low reset
//   irq   : asynchronous request lines
//   bus   : CU bus responder (addr, wdata, mem_rd, mem_wr -> rdata, oe_rdata)
//   hwint : registered interrupt request to the CU
// Register window (word offsets from BASE_ADDR):
//   0 PENDING R/W1C, 1 ENABLE RW, 2 MODE RW (1=edge), 3 CAUSE RO, 4 ACK WO, 5-7 read 0.
module intc_mmio
  import intc_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 8,
  parameter logic [15:0] BASE_ADDR   = 16'hff00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  intc_mmio_if.slave         bus,
  output logic               hwint
);

  logic [NUM_IRQ-1:0] irq_s, irq_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] edge_set, w1c_clr, ack_clr, active;
  logic               hwint_q;
  logic               sel, wr;
  logic [2:0]         off;
  cause_t             cause;
  logic [31:0]        rdata_mux;
  logic               unused_wdata;

  // Lowest active index wins.
  function automatic cause_t encode_cause(input logic [NUM_IRQ-1:0] act);
    cause_t c;
    c = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (act[i]) begin
        c.valid = 1'b1;
        c.index = 5'(i);
      end
    end
    return c;
  endfunction

  sync_bits #(
    .WIDTH  (NUM_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq),
    .q   (irq_s)
  );

  // Decode
  assign sel = (bus.mem_rd | bus.mem_wr) && (bus.addr[15:3] == BASE_ADDR[15:3]);
  assign off = bus.addr[2:0];
  assign wr  = sel & bus.mem_wr;

  assign edge_set = irq_s & ~irq_q;
  assign active   = pending_q & enable_q;
  assign cause    = encode_cause(active);

  // Only the low NUM_IRQ data bits (and [4:0] for ACK) carry meaning.
  assign unused_wdata = ^bus.wdata;

  always_comb begin
    w1c_clr  = '0;
    ack_clr  = '0;
    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr) begin
      case (off)
        INTC_PENDING: w1c_clr  = bus.wdata[NUM_IRQ-1:0];
        INTC_ENABLE:  enable_d = bus.wdata[NUM_IRQ-1:0];
        INTC_MODE:    mode_d   = bus.wdata[NUM_IRQ-1:0];
        INTC_ACK: begin
          // Indices >= NUM_IRQ match no bit and are thereby ignored.
          for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = (bus.wdata[4:0] == 5'(i));
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode_q[i] == MODE_EDGE) begin
        // A new edge beats a same-cycle clear so no request is lost.
        pending_d[i] = edge_set[i] | (pending_q[i] & ~(w1c_clr[i] | ack_clr[i]));
      end else begin
        pending_d[i] = irq_s[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      hwint_q   <= 1'b0;
    end else begin
      irq_q     <= irq_s;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      hwint_q   <= |active;
    end
  end

  assign hwint = hwint_q;

  // Read path: combinational, side-effect free.
  always_comb begin
    rdata_mux = '0;
    case (off)
      INTC_PENDING: rdata_mux = 32'(pending_q);
      INTC_ENABLE:  rdata_mux = 32'(enable_q);
      INTC_MODE:    rdata_mux = 32'(mode_q);
      INTC_CAUSE:   rdata_mux = cause;
      default:      rdata_mux = '0;
    endcase
  end

  // Keep the bus released while in reset.
  assign bus.oe_rdata = sel & bus.mem_rd & rst;
  assign bus.rdata    = bus.oe_rdata ? rdata_mux : '0;

endmodule

// File: tb/tb_intc_mmio.sv
module tb_intc_mmio;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [7:0]  irq;
    logic [31:0] exp_rdata;
    logic        exp_oe;
    logic        exp_hwint;
  } vec_t;

  localparam logic [15:0] A_P = 16'hff00;
  localparam logic [15:0] A_E = 16'hff01;
  localparam logic [15:0] A_M = 16'hff02;
  localparam logic [15:0] A_C = 16'hff03;
  localparam logic [15:0] A_K = 16'hff04;

  logic       clk;
  logic       rst;
  logic [7:0] irq;
  logic       hwint;
  int         n_vec;
  int         n_bad;
  vec_t       vecs[$];

  intc_mmio_if bus ();

  intc_mmio #(
    .NUM_IRQ     (8),
    .BASE_ADDR   (16'hff00),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .irq   (irq),
    .bus   (bus),
    .hwint (hwint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t rd_v(logic [15:0] a, logic [7:0] i, logic [31:0] e, logic oe,
                                logic hw);
    vec_t v;
    v.rd = 1'b1; v.wr = 1'b0; v.addr = a; v.wdata = '0; v.irq = i;
    v.exp_rdata = e; v.exp_oe = oe; v.exp_hwint = hw;
    return v;
  endfunction

  function automatic vec_t wr_v(logic [15:0] a, logic [31:0] d, logic [7:0] i, logic hw);
    vec_t v;
    v.rd = 1'b0; v.wr = 1'b1; v.addr = a; v.wdata = d; v.irq = i;
    v.exp_rdata = '0; v.exp_oe = 1'b0; v.exp_hwint = hw;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    bus.mem_rd = v.rd;
    bus.mem_wr = v.wr;
    bus.addr   = v.addr;
    bus.wdata  = v.wdata;
    irq        = v.irq;
    #1;
    n_vec++;
    if (bus.rdata !== v.exp_rdata || bus.oe_rdata !== v.exp_oe || hwint !== v.exp_hwint) begin
      n_bad++;
      $display("FAIL %s: got rdata=%h oe=%b hwint=%b, want rdata=%h oe=%b hwint=%b", tag,
               bus.rdata, bus.oe_rdata, hwint, v.exp_rdata, v.exp_oe, v.exp_hwint);
    end
  endtask

  initial begin
    vec_t v;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    irq = '0;
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state, enable masking, edge path and latency
    vecs.push_back(rd_v(A_P, 8'h00, 32'h0, 1'b1, 1'b0));
    vecs.push_back(rd_v(A_E, 8'h00, 32'h0, 1'b1, 1'b0));
    vecs.push_back(wr_v(A_M, 32'hff, 8'h00, 1'b0));
    vecs.push_back(wr_v(A_E, 32'hffff_ffff, 8'h00, 1'b0));
    vecs.push_back(rd_v(A_E, 8'h00, 32'h0000_00ff, 1'b1, 1'b0));
    vecs.push_back(wr_v(A_E, 32'h08, 8'h00, 1'b0));
    vecs.push_back(rd_v(A_M, 8'h00, 32'hff, 1'b1, 1'b0));
    vecs.push_back(rd_v(A_C, 8'h08, 32'h0, 1'b1, 1'b0));
    vecs.push_back(rd_v(A_P, 8'h08, 32'h0, 1'b1, 1'b0));
    vecs.push_back(rd_v(A_P, 8'h08, 32'h0, 1'b1, 1'b0));
    vecs.push_back(rd_v(A_P, 8'h08, 32'h08, 1'b1, 1'b0));
    vecs.push_back(rd_v(A_C, 8'h08, 32'h8000_0003, 1'b1, 1'b1));
    vecs.push_back(wr_v(A_P, 32'h08, 8'h08, 1'b1));
    vecs.push_back(rd_v(A_P, 8'h08, 32'h0, 1'b1, 1'b1));
    vecs.push_back(rd_v(A_C, 8'h08, 32'h0, 1'b1, 1'b0));
    // Read and write together return the pre-write value
    v = wr_v(A_E, 32'hff, 8'h08, 1'b0);
    v.rd = 1'b1; v.exp_rdata = 32'h08; v.exp_oe = 1'b1;
    vecs.push_back(v);
    vecs.push_back(rd_v(A_E, 8'h08, 32'hff, 1'b1, 1'b0));
    // Priority and ACK, including an out-of-range ACK index
    vecs.push_back(rd_v(A_P, 8'h2c, 32'h0, 1'b1, 1'b0));
    vecs.push_back(rd_v(A_P, 8'h2c, 32'h0, 1'b1, 1'b0));
    vecs.push_back(rd_v(A_P, 8'h2c, 32'h0, 1'b1, 1'b0));
    vecs.push_back(rd_v(A_C, 8'h2c, 32'h8000_0002, 1'b1, 1'b0));
    vecs.push_back(wr_v(A_K, 32'h2, 8'h2c, 1'b1));
    vecs.push_back(rd_v(A_C, 8'h2c, 32'h8000_0005, 1'b1, 1'b1));
    vecs.push_back(wr_v(A_K, 32'h9, 8'h2c, 1'b1));
    vecs.push_back(rd_v(A_P, 8'h2c, 32'h20, 1'b1, 1'b1));
    vecs.push_back(wr_v(A_K, 32'h5, 8'h2c, 1'b1));
    vecs.push_back(rd_v(A_C, 8'h2c, 32'h0, 1'b1, 1'b1));
    vecs.push_back(rd_v(A_P, 8'h2c, 32'h0, 1'b1, 1'b0));
    // Decode boundaries
    vecs.push_back(rd_v(16'hff05, 8'h2c, 32'h0, 1'b1, 1'b0));
    vecs.push_back(rd_v(16'hff08, 8'h2c, 32'h0, 1'b0, 1'b0));
    vecs.push_back(wr_v(16'hff08, 32'h0, 8'h2c, 1'b0));
    vecs.push_back(rd_v(A_M, 8'h2c, 32'hff, 1'b1, 1'b0));
    // Level mode: follows irq_s, ignores W1C, edge->level switch
    vecs.push_back(wr_v(A_E, 32'h01, 8'h2c, 1'b0));
    vecs.push_back(wr_v(A_M, 32'h00, 8'h01, 1'b0));
    vecs.push_back(rd_v(A_P, 8'h01, 32'h0, 1'b1, 1'b0));
    vecs.push_back(rd_v(A_P, 8'h01, 32'h2c, 1'b1, 1'b0));
    vecs.push_back(rd_v(A_P, 8'h01, 32'h01, 1'b1, 1'b0));
    vecs.push_back(wr_v(A_P, 32'h01, 8'h01, 1'b1));
    vecs.push_back(rd_v(A_P, 8'h01, 32'h01, 1'b1, 1'b1));
    vecs.push_back(rd_v(A_P, 8'h00, 32'h01, 1'b1, 1'b1));
    vecs.push_back(rd_v(A_P, 8'h00, 32'h01, 1'b1, 1'b1));
    vecs.push_back(rd_v(A_P, 8'h00, 32'h01, 1'b1, 1'b1));
    vecs.push_back(rd_v(A_P, 8'h00, 32'h00, 1'b1, 1'b1));
    vecs.push_back(rd_v(A_C, 8'h00, 32'h0, 1'b1, 1'b0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Set/clear collision on irq[1]: W1C lands in the cycle a new edge is detected
    apply(wr_v(A_M, 32'hff, 8'h00, 1'b0), "col_mode");
    apply(wr_v(A_E, 32'h02, 8'h00, 1'b0), "col_en");
    apply(rd_v(A_P, 8'h02, 32'h0, 1'b1, 1'b0), "col_rise0");
    apply(rd_v(A_P, 8'h02, 32'h0, 1'b1, 1'b0), "col_rise1");
    apply(rd_v(A_P, 8'h02, 32'h0, 1'b1, 1'b0), "col_rise2");
    apply(rd_v(A_P, 8'h02, 32'h02, 1'b1, 1'b0), "col_set");
    apply(wr_v(A_P, 32'h02, 8'h00, 1'b1), "col_w1c");
    apply(rd_v(A_P, 8'h00, 32'h0, 1'b1, 1'b1), "col_cleared");
    apply(rd_v(A_P, 8'h00, 32'h0, 1'b1, 1'b0), "col_low");
    apply(rd_v(A_P, 8'h02, 32'h0, 1'b1, 1'b0), "col_rise3");
    apply(rd_v(A_P, 8'h02, 32'h0, 1'b1, 1'b0), "col_rise4");
    apply(wr_v(A_P, 32'h02, 8'h02, 1'b0), "col_collide");
    apply(rd_v(A_P, 8'h02, 32'h02, 1'b1, 1'b0), "col_kept");
    apply(rd_v(A_C, 8'h02, 32'h8000_0001, 1'b1, 1'b1), "col_cause");

    // Asynchronous reset while an interrupt is pending and hwint is high
    @(negedge clk);
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    irq = '0;
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (hwint !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async: got hwint=%b, want hwint=0", hwint);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    apply(rd_v(A_P, 8'h00, 32'h0, 1'b1, 1'b0), "rst_pending");
    apply(rd_v(A_M, 8'h00, 32'h0, 1'b1, 1'b0), "rst_mode");
    apply(rd_v(A_E, 8'h00, 32'h0, 1'b1, 1'b0), "rst_enable");

    @(negedge clk);
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
